uart_tx_fifo: RTL

//  Transmit side of the UART: serialises bytes queued by the CPU/bus into 8N1 frames (1 start, WIDTH data

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO: 8N1 frames, LSB first, back-to-back frames.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      clock_divider,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
`ifdef UART_TX_PARITY_EN
    input  logic             parity_odd,
`endif
    output logic             tx,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW:0]   FULL_CNT = (CW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]    wr_ptr, rd_ptr;
    logic [CW:0]      count;
    logic             push, pop;
    logic [WIDTH-1:0] head;

    state_t           state, state_n;
    logic [15:0]      cnt, cnt_n;
    logic [15:0]      div_lat, div_n;
    logic [15:0]      div_eff;
    logic [BW-1:0]    bit_idx, bit_idx_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic             tx_n;
    logic             last;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_n;
`endif

    assign push    = write_en && ready;
    assign head    = mem[rd_ptr];
    assign ready   = (count < FULL_CNT);
    assign busy    = (state != IDLE) || (count != '0);
    assign div_eff = (clock_divider == 16'd0) ? 16'd1 : clock_divider;
    assign last    = (cnt == div_lat);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
            case ({push, pop})
                2'b10:   count <= count + (CW + 1)'(1);
                2'b01:   count <= count - (CW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= 16'd1;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_lat <= div_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = div_lat;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n     = par_q;
`endif
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (count != '0) pop = 1'b1;
            end
            START: begin
                if (last) begin
                    cnt_n     = 16'd1;
                    tx_n      = shift[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_n = 16'd1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_n    = par_q;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    cnt_n   = 16'd1;
                    tx_n    = 1'b1;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    cnt_n = 16'd1;
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase

        // Frame start shared by IDLE and the last STOP cycle, so frames chain without a gap.
        if (pop) begin
            shift_n = head;
            div_n   = div_eff;
            cnt_n   = 16'd1;
            tx_n    = 1'b0;
            state_n = START;
`ifdef UART_TX_PARITY_EN
            par_n   = (^head) ^ parity_odd;
`endif
        end
    end

endmodule
